// File: rtl/alu_pkg.sv
// Shared types and constants for the start/done handshaked ALU.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 4;

  // Operation select, full 3-bit decode.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: eight WIDTH-bit operations, results truncated, no flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  opcode_e            opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y
);

  // Decode the opcode and produce the truncated result.
  always_comb begin
    // NOTE: y gets a default before the case so no path leaves it unassigned, which would infer a latch.
    y = '0;
    case (opcode)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_SHL:  y = a << 1;
      OP_SHR:  y = a >> 1;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_fsm.sv
// Start/done handshaked multi-cycle ALU: capture on start, compute in EXEC,
// hold the registered result with done high in DONE.
module alu_fsm
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_y;

  // The ALU only ever sees the captured operands, so input changes during EXEC are ignored.
  alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode (opcode_e'(op_q)),
    .a      (a_q),
    .b      (b_q),
    .y      (alu_y)
  );

  // Next-state and register-update logic; everything holds unless a transition says otherwise.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          a_d     = A;
          b_d     = B;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // start is deliberately not looked at here.
        result_d = alu_y;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          // result is kept; only done falls while the new operation executes.
          op_d    = opcode;
          a_d     = A;
          b_d     = B;
          state_d = S_EXEC;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that overrides any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_fsm.sv
// Scoreboard bench for alu_fsm: stimulus pushes hand-computed results, a monitor
// pops and compares each time done rises.
module tb_alu_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] opcode;
  logic [3:0] A, B;
  logic       done;
  logic [3:0] result;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];

  alu_fsm #(.WIDTH(4), .OPW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .A      (A),
    .B      (B),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Issue one operation from IDLE/DONE and wait until its result is due.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] exp, input string nm);
    start  = 1'b1;
    opcode = op;
    A      = a;
    B      = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: every rising edge of done presents one result to the scoreboard.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got result %0d with no operation outstanding", result);
        end else begin
          logic [3:0] e;
          string      s;
          e = exp_q.pop_front();
          s = name_q.pop_front();
          check(s, result, e);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
    string      nm;
  } vec_t;

  vec_t vecs[7] = '{
    '{3'd0, 4'd15, 4'd1,  4'd0,  "add_wrap"},
    '{3'd1, 4'd0,  4'd1,  4'd15, "sub_wrap"},
    '{3'd6, 4'd9,  4'd0,  4'd2,  "shl"},
    '{3'd7, 4'd9,  4'd0,  4'd4,  "shr"},
    '{3'd5, 4'd5,  4'd7,  4'd10, "not"},
    '{3'd4, 4'd12, 4'd10, 4'd6,  "xor"},
    '{3'd3, 4'd12, 4'd3,  4'd15, "or"}
  };

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; A = '0; B = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_done", done, 0);

    // ADD, then confirm the result holds while start stays low.
    issue(3'd0, 4'd10, 4'd5, 4'd15, "add");
    check("add_done", done, 1);
    repeat (2) @(posedge clk);
    #1;
    check("add_hold_result", result, 15);
    check("add_hold_done", done, 1);

    // SUB then AND back-to-back from DONE.
    issue(3'd1, 4'd9, 4'd4, 4'd5, "sub");
    start = 1'b1; opcode = 3'd2; A = 4'd12; B = 4'd6;
    exp_q.push_back(4'd4); name_q.push_back("and");
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_drop", done, 0);
    check("b2b_result_kept", result, 5);
    @(posedge clk); #1;
    check("b2b_and_done", done, 1);

    // Wrap, shift, logic vectors.
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

    // start held high: a new op is accepted in every DONE cycle.
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; opcode = 3'd0; A = 4'(i + 3); B = 4'd1;
      exp_q.push_back(4'(i + 4)); name_q.push_back("start_held");
      @(posedge clk); #1;
      check("held_exec_done_low", done, 0);
      @(posedge clk); #1;
    end
    start = 1'b0;

    // Inputs and start changed during EXEC are ignored.
    start = 1'b1; opcode = 3'd1; A = 4'd9; B = 4'd3;
    exp_q.push_back(4'd6); name_q.push_back("exec_stability");
    @(posedge clk); #1;
    opcode = 3'd0; A = 4'd15; B = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_op_done", done, 1);
    check("no_extra_op_result", result, 6);

    // Reset during EXEC discards the operation.
    start = 1'b1; opcode = 3'd0; A = 4'd1; B = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_stays_idle", done, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_fsm.md
Name: alu_fsm

Overview:
- Multi-cycle, start/done handshaked 4-bit ALU controlled by a small FSM.
- A one-cycle `start` pulse captures `opcode`, `A` and `B`. The block computes one of eight operations, registers the result and raises `done`.
- Used as a simple synthesizable datapath+control block. Upstream logic issues one operation at a time.

Parameters:
- WIDTH, 4, operand and result width in bits.
- OPW, 3, opcode width in bits (fixed at 3; eight operations).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on rising clk in IDLE or DONE.
- opcode  input  OPW  operation select; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- done  output  1  registered; high while a valid result is held.
- result  output  WIDTH  registered operation result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE; done=0; result=0; operand/opcode registers=0.
  - Reset has priority over everything, including mid-operation; any in-flight operation is discarded.
- States: IDLE, EXEC, DONE (2-bit encoding).
- IDLE:
  - done=0.
  - If start=1: latch opcode/A/B into internal registers, go to EXEC. Otherwise stay.
- EXEC:
  - Compute from the latched registers only; input changes are ignored.
  - Write result, go to DONE. start is ignored in this state.
- DONE:
  - done=1, result held stable.
  - If start=1: latch new inputs, go to EXEC, done falls on that same edge. Otherwise stay in DONE with done=1.
- Latency:
  - start sampled at edge N; result and done=1 valid after edge N+1.
  - One EXEC cycle, so done is visible from the cycle following the capture cycle.
- result changes only on the EXEC->DONE edge or on reset; it is never cleared by a new start.
- Operations (all WIDTH-bit, results truncated, no flags):
  - 0 ADD: A+B mod 2^WIDTH.
  - 1 SUB: A-B mod 2^WIDTH (two's-complement wrap).
  - 2 AND: A&B.
  - 3 OR: A|B.
  - 4 XOR: A^B.
  - 5 NOT: ~A (B ignored).
  - 6 SHL: A<<1, zero fill.
  - 7 SHR: A>>1, zero fill (logical).
- Boundary cases:
  - ADD overflow wraps: 15+1 = 0.
  - SUB underflow wraps: 0-1 = 15.
  - start held high continuously: a new op is accepted every time the FSM is in DONE, giving an EXEC/DONE alternation with done toggling.
  - start in EXEC has no effect.
  - Unknown/X opcode is not possible (full 3-bit decode). The default branch yields 0.

Decomposition:
- Package alu_pkg:
  - opcode enum (OP_ADD..OP_SHR, 3-bit).
  - state enum (S_IDLE, S_EXEC, S_DONE).
  - WIDTH default constant.
- One natural sub-module: alu_core, purely combinational: opcode, a, b -> y.
- alu_fsm holds the state register, operand/opcode capture registers and output registers, and instantiates alu_core.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, release -> done=0, result=0, stays IDLE while start=0.
- ADD: opcode=0, A=10, B=5, start pulse -> one cycle later done=1, result=15. Result holds while start=0.
- SUB then AND back-to-back from DONE:
  - opcode=1, A=9, B=4 -> result=5, done=1.
  - Then opcode=2, A=12, B=6 -> done drops for one cycle, then result=4, done=1.
- Wrap and shifts:
  - ADD 15+1 -> 0.
  - SUB 0-1 -> 15.
  - SHL A=9 -> 2.
  - SHR A=9 -> 4.
  - NOT A=5 -> 10.
  - XOR 12^10 -> 6.
  - OR 12|3 -> 15.
- Input stability: change A/B/opcode during EXEC and assert start in EXEC -> result reflects captured values and no extra operation starts.
- Reset mid-operation: assert rst in the EXEC cycle -> next cycle IDLE, done=0, result=0, no DONE reached.
